// File: rtl/ddr3_rd_pkg.sv
// Shared types and helpers for the DDR3 burst read engine.
// Byte-lane masks are built at MASK_MAX width and truncated by the caller to
// its own lane count, so one helper serves every DATA_W up to 1024 bits.
package ddr3_rd_pkg;

    localparam int MASK_MAX = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Lanes at or above the start offset carry requested bytes.
    function automatic logic [MASK_MAX-1:0] head_mask(input logic [7:0] off);
        logic [MASK_MAX-1:0] m;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (i >= int'(off));
        end
        return m;
    endfunction

    // Lanes below the end offset carry requested bytes; zero means the whole word.
    function automatic logic [MASK_MAX-1:0] tail_mask(input logic [7:0] end_lane);
        logic [MASK_MAX-1:0] m;
        for (int i = 0; i < MASK_MAX; i++) begin
            m[i] = (end_lane == 8'd0) || (i < int'(end_lane));
        end
        return m;
    endfunction

endpackage

// File: rtl/ddr3_rd_fifo.sv
// Single-clock FIFO with registered read port, occupancy count and a
// synchronous flush that discards everything held.
module ddr3_rd_fifo
    import ddr3_rd_pkg::*;
#(
    parameter int WIDTH = 288,
    parameter int DEPTH = 128,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      usedw,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    assign usedw = wr_ptr_q - rd_ptr_q;
    assign full  = (usedw == (AW+1)'(DEPTH));
    assign empty = (usedw == '0);
    assign do_wr = wr_en & ~full & ~flush;
    assign do_rd = rd_en & ~empty & ~flush;

    // Storage array: write port and registered read port, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
        if (do_rd) begin
            rd_data <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer and read-valid bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ddr3_burst_reader.sv
// DDR3 burst read engine: turns a byte-addressed read command into EMIF
// bursts gated by FIFO credit, tags each returned beat with a byte-valid
// mask and queues it for the downstream consumer.
// Optional feature macro: DDR3_RD_ABORT_EN adds rd_abort_in.
module ddr3_burst_reader
    import ddr3_rd_pkg::*;
#(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 22,
    parameter int BADDR_W    = ADDR_W + clog2(DATA_W / 8),
    parameter int BURST_MAX  = 16,
    parameter int BC_W       = 5,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                       ddr3_emif_clk,
    input  logic                       ddr3_emif_rst,
    input  logic                       ddr3_emif_ready,
    input  logic [DATA_W-1:0]          ddr3_emif_read_data,
    input  logic                       ddr3_emif_rddata_valid,
    output logic                       ddr3_emif_read,
    output logic                       ddr3_emif_write,
    output logic [ADDR_W-1:0]          ddr3_emif_addr,
    output logic [DATA_W-1:0]          ddr3_emif_write_data,
    output logic [DATA_W/8-1:0]        ddr3_emif_byte_enable,
    output logic [BC_W-1:0]            ddr3_emif_burst_count,
    input  logic [BADDR_W-1:0]         rd_start_addr_in,
    input  logic [31:0]                rd_byte_count_in,
    input  logic                       rd_start_in,
`ifdef DDR3_RD_ABORT_EN
    input  logic                       rd_abort_in,
`endif
    output logic                       rd_busy_out,
    output logic                       rd_done_out,
    input  logic                       read_req_in,
    output logic                       data_ready_out,
    output logic [DATA_W+DATA_W/8-1:0] read_data_out,
    output logic                       read_data_valid_out
);

    localparam int BYTES   = DATA_W / 8;
    localparam int LOG_B   = clog2(BYTES);
    localparam int FIFO_AW = clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 2;
    localparam int BEAT_W  = 33;
    localparam int WORD_W  = DATA_W + BYTES;

    rd_state_t           state_q;
    logic [LOG_B-1:0]    off_q;
    logic [LOG_B-1:0]    end_q;
    logic [BEAT_W-1:0]   total_q;
    logic [BEAT_W-1:0]   to_issue_q;
    logic [BEAT_W-1:0]   recv_idx_q;
    logic [CNT_W-1:0]    outstanding_q;
    logic                read_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BC_W-1:0]     bc_q;
    logic                done_q;
    logic                aborted_q;
    logic                wr_en_q;
    logic [WORD_W-1:0]   wr_data_q;

    logic                accept;
    logic                beat_in;
    logic                keep_beat;
    logic                abort_req;
    logic [BEAT_W-1:0]   remain;
    logic [CNT_W-1:0]    out_eff;
    logic [CNT_W-1:0]    used_tot;
    logic [CNT_W-1:0]    avail;
    logic [BC_W-1:0]     l_next;
    logic                can_issue;
    logic [CNT_W-1:0]    outstanding_d;
    logic [LOG_B-1:0]    start_off;
    logic [BEAT_W-1:0]   start_beats;
    logic [BYTES-1:0]    beat_mask;

    logic [FIFO_AW:0]    fifo_usedw;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_flush;

`ifdef DDR3_RD_ABORT_EN
    assign abort_req = rd_abort_in & (state_q == ST_ISSUE);
`else
    assign abort_req = 1'b0;
`endif

    // Credit check, outstanding-beat arithmetic and the mask of the beat arriving now.
    always_comb begin
        start_off   = rd_start_addr_in[LOG_B-1:0];
        start_beats = ({1'b0, rd_byte_count_in} + BEAT_W'(start_off)
                       + BEAT_W'(BYTES - 1)) >> LOG_B;

        accept    = read_q & ddr3_emif_ready;
        // Beats with nothing outstanding belong to a command abandoned by reset.
        beat_in   = ddr3_emif_rddata_valid & (outstanding_q != '0);
        keep_beat = beat_in & ~aborted_q & ~abort_req;

        remain  = accept ? (to_issue_q - BEAT_W'(bc_q)) : to_issue_q;
        out_eff = outstanding_q + (accept ? CNT_W'(bc_q) : CNT_W'(0));
        l_next  = (remain > BEAT_W'(BURST_MAX)) ? BC_W'(BURST_MAX) : BC_W'(remain);

        // The staged beat not yet in the FIFO still occupies a slot.
        used_tot  = CNT_W'(fifo_usedw) + CNT_W'(wr_en_q) + out_eff;
        avail     = CNT_W'(FIFO_DEPTH) - used_tot;
        can_issue = (remain != '0) && !fifo_full && (avail >= CNT_W'(l_next));

        outstanding_d = out_eff - (beat_in ? CNT_W'(1) : CNT_W'(0));

        beat_mask = '1;
        if (recv_idx_q == '0) begin
            beat_mask = beat_mask & BYTES'(head_mask(8'(off_q)));
        end
        if (recv_idx_q == total_q - BEAT_W'(1)) begin
            beat_mask = beat_mask & BYTES'(tail_mask(8'(end_q)));
        end
    end

    // Command FSM: latches the request, presents credit-gated bursts and waits out returns.
    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            state_q       <= ST_IDLE;
            off_q         <= '0;
            end_q         <= '0;
            total_q       <= '0;
            to_issue_q    <= '0;
            recv_idx_q    <= '0;
            outstanding_q <= '0;
            read_q        <= 1'b0;
            addr_q        <= '0;
            bc_q          <= '0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            outstanding_q <= outstanding_d;
            if (beat_in) begin
                recv_idx_q <= recv_idx_q + BEAT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (rd_start_in) begin
                        off_q      <= start_off;
                        end_q      <= start_off + rd_byte_count_in[LOG_B-1:0];
                        addr_q     <= rd_start_addr_in[BADDR_W-1:LOG_B];
                        total_q    <= start_beats;
                        to_issue_q <= start_beats;
                        recv_idx_q <= '0;
                        if (rd_byte_count_in == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (abort_req) begin
                        aborted_q <= 1'b1;
                    end
                    if (accept) begin
                        addr_q     <= addr_q + ADDR_W'(bc_q);
                        to_issue_q <= remain;
                    end
                    // A presented burst stays frozen until the EMIF takes it.
                    if (!read_q || accept) begin
                        if (remain == '0 || aborted_q || abort_req) begin
                            read_q  <= 1'b0;
                            state_q <= ST_DRAIN;
                        end else if (can_issue) begin
                            read_q <= 1'b1;
                            bc_q   <= l_next;
                        end else begin
                            read_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    aborted_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stage each kept beat with its mask; it lands in the FIFO on the following cycle.
    always_ff @(posedge ddr3_emif_clk or posedge ddr3_emif_rst) begin
        if (ddr3_emif_rst) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= keep_beat;
            if (keep_beat) begin
                wr_data_q <= {ddr3_emif_read_data, beat_mask};
            end
        end
    end

    assign fifo_flush = aborted_q | abort_req;

    ddr3_rd_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (ddr3_emif_clk),
        .rst      (ddr3_emif_rst),
        .flush    (fifo_flush),
        .wr_en    (wr_en_q),
        .wr_data  (wr_data_q),
        .rd_en    (read_req_in),
        .rd_data  (read_data_out),
        .rd_valid (read_data_valid_out),
        .usedw    (fifo_usedw),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ddr3_emif_read        = read_q;
    assign ddr3_emif_addr        = addr_q;
    assign ddr3_emif_burst_count = bc_q;
    assign ddr3_emif_write       = 1'b0;
    assign ddr3_emif_write_data  = '0;
    assign ddr3_emif_byte_enable = '1;
    assign rd_busy_out           = (state_q != ST_IDLE);
    assign rd_done_out           = done_q;
    assign data_ready_out        = ~fifo_empty;

endmodule

// File: doc/ddr3_burst_reader.md
# ddr3_burst_reader

Parametrised DDR3 read engine that sits between the Avalon-MM EMIF read port and the frame/output logic. It accepts a byte-addressed read command and issues multi-beat bursts with FIFO-credit flow control. It counts returned beats using the real `rddata_valid` strobe rather than a fixed latency, and buffers each beat with a per-byte valid mask (head and tail trimming) in an internal FIFO for the downstream consumer.

## Interface
Parameters:
- `DATA_W`, 256: EMIF data width; `BYTES = DATA_W/8` (power of two).
- `ADDR_W`, 22: EMIF word address width.
- `BADDR_W`, `ADDR_W + log2(BYTES)`: byte address width.
- `BURST_MAX`, 16: maximum beats per burst (1..2^`BC_W`-1).
- `BC_W`, 5: burst count port width.
- `FIFO_DEPTH`, 128: output FIFO depth in words (power of two, ≥ `BURST_MAX`).

Ports:
- `ddr3_emif_clk` in 1: sole clock.
- `ddr3_emif_rst` in 1: reset. **One clock; reset is asynchronous and active-high.**
- `ddr3_emif_ready` in 1: EMIF accepts command (inverse waitrequest).
- `ddr3_emif_read_data` in `DATA_W`: read data.
- `ddr3_emif_rddata_valid` in 1: read beat valid.
- `ddr3_emif_read` out 1: read command.
- `ddr3_emif_write` out 1: constant 0.
- `ddr3_emif_addr` out `ADDR_W`: burst start word address.
- `ddr3_emif_write_data` out `DATA_W`: constant 0.
- `ddr3_emif_byte_enable` out `BYTES`: constant all-ones.
- `ddr3_emif_burst_count` out `BC_W`: beats in current burst.
- `rd_start_addr_in` in `BADDR_W`: byte start address.
- `rd_byte_count_in` in 32: bytes to read.
- `rd_start_in` in 1: one-cycle command strobe.
- `rd_busy_out` out 1: command in progress.
- `rd_done_out` out 1: one-cycle completion pulse.
- `read_req_in` in 1: pop FIFO.
- `data_ready_out` out 1: FIFO not empty.
- `read_data_out` out `DATA_W+BYTES`: `{data, byte_valid}`.
- `read_data_valid_out` out 1: `read_data_out` valid.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: `rd_start_in` latches `off = addr[log2(BYTES)-1:0]`, word address `addr >> log2(BYTES)`, and count.
  - Total beats `T = (off + count + BYTES-1) >> log2(BYTES)`, computed with a 33-bit intermediate.
  - count == 0 goes directly to DONE with no reads. Otherwise go to ISSUE.
  - `rd_start_in` outside IDLE is ignored.
- ISSUE:
  - Burst length `L = min(BURST_MAX, beats_to_issue)`.
  - A burst is presented only when `FIFO_DEPTH - fifo_used - outstanding ≥ L`.
  - Once `ddr3_emif_read` is asserted, `read`, `addr` and `burst_count` are held stable until sampled with `ddr3_emif_ready`=1.
  - On acceptance: `addr += L`, `beats_to_issue -= L`, `outstanding += L`.
  - When `beats_to_issue` reaches 0, go to DRAIN.
- Receive path (any state): each `rddata_valid` beat is written to the FIFO with mask `m`, and `outstanding` is decremented.
  - Mask bit i corresponds to byte lane i (`data[8i+7:8i]`).
  - First beat: bits `i ≥ off`.
  - Last beat: bits `i < end`, where `end = (off+count) mod BYTES`; `end` == 0 means all bits.
  - Single-beat transfer: AND of the first-beat and last-beat masks.
  - Middle beats: all-ones.
- DRAIN: wait for `outstanding` == 0, then go to DONE.
- DONE: assert `rd_done_out` for one cycle, then go to IDLE. `rd_busy_out` = (state != IDLE).
- Simultaneous accept and return in one cycle: `outstanding` is updated as `+L-1`.
- Output side:
  - `data_ready_out` = ~empty.
  - `read_req_in` while empty is ignored.
  - `read_req_in` while not empty pops one word.

## Timing
- Reset values:
  - `ddr3_emif_read`=0, `ddr3_emif_addr`=0, `ddr3_emif_burst_count`=0.
  - `rd_busy_out`=0, `rd_done_out`=0, `read_data_valid_out`=0.
  - FIFO empty, so `data_ready_out`=0.
  - Reset mid-transfer abandons all state; stale returning beats after reset are dropped.
- `rd_start_in` sampled at cycle 0 → `ddr3_emif_read` high at cycle 1 at the earliest.
- Consecutive bursts may issue back-to-back (no idle cycle) when credit allows.
- `rddata_valid` at cycle n → FIFO write at n+1 → `data_ready_out` high at n+2 at the latest.
- Last FIFO write at cycle n → state DONE, `rd_done_out` at n+1.
- `read_req_in` at cycle n with FIFO not empty → `read_data_valid_out`=1 and data valid at n+1.

## Configuration
- `DDR3_RD_ABORT_EN` defined:
  - Adds input `rd_abort_in` (1 bit).
  - In ISSUE, the abort stops further issuing; a burst already presented is held until accepted. The block then goes to DRAIN.
  - Returning beats after abort are discarded, and the FIFO is flushed.
  - `rd_done_out` still pulses once when `outstanding` reaches 0.
- Undefined: no port and no abort logic.

## Structure
- Package `ddr3_rd_pkg`:
  - State enum typedef.
  - Functions `head_mask(off)`, `tail_mask(end)`, `clog2`.
- Sub-module `ddr3_rd_fifo`:
  - Parametrised single-clock FIFO of width `DATA_W+BYTES` and depth `FIFO_DEPTH`.
  - Exposes `usedw`, `full` and `empty`, with one-cycle registered read.

## Test plan
- Defaults, addr 0x40, count 64, ready=1, 5-cycle return latency → one burst (L=2, addr 2), two FIFO words with mask 0xFFFFFFFF, one `rd_done_out` pulse.
- Addr 0x23, count 40 → T=2; masks 0xFFFFFFF8 and 0x000007FF.
- Addr 0x05, count 3 → single beat, mask 0x000000E0.
- Count 4096 with `read_req_in` held low → no burst issued once FIFO used+outstanding would exceed 128; issuing resumes after pops; total 128 beats in order.
- `ddr3_emif_ready` low for 7 cycles during a burst → addr and burst_count stable throughout; no duplicate command issued.
- Count 0 → `rd_done_out` pulse without any `ddr3_emif_read`. Separately, `ddr3_emif_rst` asserted mid-burst → all outputs return to reset values within the same cycle.
